// File: rtl/vga_pkg.sv
// vga_pkg: shared FSM state type and nominal VGA timing / grid constants
package vga_pkg;
  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
  localparam int H_VIS   = 640;
  localparam int V_VIS   = 480;
  localparam int GRID_X0 = 211;
  localparam int GRID_X1 = 423;
  localparam int GRID_Y0 = 158;
  localparam int GRID_Y1 = 317;
endpackage

// File: rtl/vga_edge_det.sv
// vga_edge_det: input register plus one-cycle history, giving rise/fall pulses
module vga_edge_det
  import vga_pkg::*;
#(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);
  logic r_q, r_prev;
  // capture the pin and remember the previous captured value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_q    <= INIT;
      r_prev <= INIT;
    end else begin
      r_q    <= i_d;
      r_prev <= r_q;
    end
  assign o_q    = r_q;
  assign o_rise = r_q & ~r_prev;
  assign o_fall = ~r_q & r_prev;
endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers x/y from a VGA sync/blank stream, measures timing and locks (grid marker under VGA_DECODER_GRID_EN)
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int N           = 9,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vga_hsync_n,
  input  logic       vga_vsync_n,
  input  logic       vga_blank,
  output logic [N:0] x,
  output logic [N:0] y,
  output logic       active,
  output logic       frame_start,
  output logic [N:0] h_total,
  output logic [N:0] v_total,
  output logic       locked,
  output logic       sync_err,
  output logic       on_grid
);
  logic w_hs, w_hs_rise, w_line;
  logic w_vs, w_vs_rise, w_frame;
  logic w_bl, w_bl_rise, w_bl_fall;
  logic w_unused;
  logic [N:0] r_hcnt, r_hmeas, r_vcnt, r_x, r_y, r_htot, r_vtot;
  logic [N:0] w_hm, w_vm, w_x_nxt, w_y_nxt;
  logic r_act, r_fs, r_pend, r_err, w_pend, w_err, w_ld;
  logic [2:0] r_match, w_match_nxt;
  state_t r_state, w_nxt;

  vga_edge_det #(.INIT(1'b1)) u_hs (.clk(clk), .rst_n(rst_n), .i_d(vga_hsync_n), .o_q(w_hs), .o_rise(w_hs_rise), .o_fall(w_line));
  vga_edge_det #(.INIT(1'b1)) u_vs (.clk(clk), .rst_n(rst_n), .i_d(vga_vsync_n), .o_q(w_vs), .o_rise(w_vs_rise), .o_fall(w_frame));
  vga_edge_det #(.INIT(1'b0)) u_bl (.clk(clk), .rst_n(rst_n), .i_d(vga_blank), .o_q(w_bl), .o_rise(w_bl_rise), .o_fall(w_bl_fall));

  assign w_unused = &{1'b0, w_hs, w_hs_rise, w_vs, w_vs_rise};

  // line length as seen this cycle: a line event exposes the just-finished count
  assign w_hm = w_line ? r_hcnt : r_hmeas;
  // line count including a coincident line event, so the line latch wins
  assign w_vm = (w_line && !(&r_vcnt)) ? r_vcnt + 1'b1 : r_vcnt;
  assign w_x_nxt = w_bl_rise ? '0 : (w_bl ? r_x + 1'b1 : r_x);
  assign w_y_nxt = w_frame ? '0 : (w_bl_fall ? r_y + 1'b1 : r_y);
  assign w_pend = w_frame | r_pend;

  // saturating line/frame length counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_hcnt  <= '0;
      r_hmeas <= '0;
      r_vcnt  <= '0;
    end else begin
      r_hcnt <= w_line ? (N+1)'(1) : (&r_hcnt ? r_hcnt : r_hcnt + 1'b1);
      if (w_line) r_hmeas <= r_hcnt;
      r_vcnt <= w_frame ? '0 : w_vm;
    end

  // visible coordinates, qualifier and first-pixel pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_act  <= 1'b0;
      r_fs   <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_act  <= w_bl;
      r_fs   <= w_bl_rise & w_pend;
      r_pend <= w_pend & ~w_bl_rise;
    end

  // lock FSM next state: measure one frame, verify LOCK_FRAMES more, then watch every event
  always_comb begin
    w_nxt       = r_state;
    w_match_nxt = r_match;
    w_err       = 1'b0;
    w_ld        = 1'b0;
    case (r_state)
      SEARCH: if (w_frame) w_nxt = MEASURE;
      MEASURE:
        if (w_frame) begin
          w_ld        = 1'b1;
          w_match_nxt = '0;
          w_nxt       = VERIFY;
        end
      VERIFY:
        if (w_frame) begin
          if (w_hm == r_htot && w_vm == r_vtot) begin
            w_match_nxt = r_match + 3'd1;
            if (w_match_nxt == 3'(LOCK_FRAMES)) w_nxt = LOCKED;
          end else begin
            w_err = 1'b1;
            w_nxt = SEARCH;
          end
        end
      LOCKED:
        if ((w_line && w_hm != r_htot) || (w_frame && w_vm != r_vtot)) begin
          w_err = 1'b1;
          w_nxt = SEARCH;
        end
      default: w_nxt = SEARCH;
    endcase
  end

  // lock FSM state, match count, reference totals and error pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= SEARCH;
      r_match <= '0;
      r_htot  <= '0;
      r_vtot  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_match <= w_match_nxt;
      if (w_ld) begin
        r_htot <= w_hm;
        r_vtot <= w_vm;
      end
      r_err <= w_err;
    end

`ifdef VGA_DECODER_GRID_EN
  logic r_grid;
  // board-line marker computed from next x/y so it lines up with them
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_grid <= 1'b0;
    else r_grid <= w_bl && (w_x_nxt == (N+1)'(GRID_X0) || w_x_nxt == (N+1)'(GRID_X1) ||
                            w_y_nxt == (N+1)'(GRID_Y0) || w_y_nxt == (N+1)'(GRID_Y1));
  assign on_grid = r_grid;
`else
  assign on_grid = 1'b0;
`endif

  assign x           = r_x;
  assign y           = r_y;
  assign active      = r_act;
  assign frame_start = r_fs;
  assign h_total     = r_htot;
  assign v_total     = r_vtot;
  assign locked      = (r_state == LOCKED);
  assign sync_err    = r_err;
endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart to the display timing comparator. It samples a VGA-style hsync/vsync/blank stream in the pixel-clock domain and recovers pixel coordinates. It measures line and frame lengths and declares lock once the timing is stable. It sits in front of frame-capture and self-check logic, so the bench and downstream blocks can verify the display path without trusting the generator's counters.

## Interface
- N, 9: coordinate/counter MSB index; all counts are N+1 bits.
- LOCK_FRAMES, 2: consecutive matching frames required to enter LOCKED (1..7).
- clk  in  1  pixel clock, one pixel per cycle.
- rst_n  in  1  reset, asynchronous assert, active-low.
- vga_hsync_n  in  1  horizontal sync, active-low.
- vga_vsync_n  in  1  vertical sync, active-low.
- vga_blank  in  1  display-enable: 1 = visible pixel, 0 = blanking.
- x  out  N+1  column inside the visible area, 0-based.
- y  out  N+1  row inside the visible area, 0-based.
- active  out  1  registered copy of the visible-pixel qualifier for x/y.
- frame_start  out  1  one-cycle pulse on the first visible pixel of a frame.
- h_total  out  N+1  last measured clocks per line.
- v_total  out  N+1  last measured lines per frame.
- locked  out  1  timing stable.
- sync_err  out  1  one-cycle pulse when a locked or verifying frame mismatches.
- on_grid  out  1  grid-line marker (see Configuration).

## Operation
- All inputs are registered once on entry (stage S1). Edges are detected from S1 against the previous S1 value.
- Line event: falling edge of hsync_n. Frame event: falling edge of vsync_n.
- The h counter counts clocks since the last line event; on each line event it latches into h_meas and restarts at 1.
- The v counter counts line events since the last frame event; on each frame event it latches into v_meas and restarts at 0.
- Both counters saturate at all-ones and never wrap.
- x resets to 0 on the cycle blank rises and increments each visible cycle. It holds its value while blank is low.
- y resets to 0 at the frame event. It increments on each blank falling edge that follows a visible run, so the first visible line is y=0.
- FSM:
  - SEARCH (reset state): on a frame event, go to MEASURE.
  - MEASURE: on the next frame event, capture h_meas/v_meas into h_total/v_total, clear the match counter, and go to VERIFY.
  - VERIFY: at each frame event, compare the current h_meas/v_meas with h_total/v_total.
    - On a match, increment the match counter. When it reaches LOCK_FRAMES, go to LOCKED.
    - On a mismatch, pulse sync_err and go to SEARCH.
  - LOCKED: check at every line event that h_meas == h_total, and at every frame event that v_meas == v_total.
    - Any mismatch pulses sync_err, drops locked in the same cycle, and returns to SEARCH.
- locked = (state == LOCKED).
- x, y, active and frame_start operate in every state. Downstream qualifies them with locked.
- Simultaneous line and frame events: the line latch is performed first, then the frame latch uses the updated v count.

## Timing
- Reset values: x=0, y=0, active=0, frame_start=0, h_total=0, v_total=0, locked=0, sync_err=0, on_grid=0; FSM in SEARCH; counters 0.
- Latency: input pin to x/y/active/on_grid is 2 cycles (S1 plus the output register). frame_start has the same 2-cycle latency.
- locked rises 1 cycle after the frame event that completes the last matching frame.
- sync_err and the fall of locked occur 1 cycle after the mismatching event.
- Reset asserted mid-frame clears everything immediately. After release, lock takes at least LOCK_FRAMES+2 frame events.

## Configuration
- VGA_DECODER_GRID_EN defined: on_grid = active && (x==211 || x==423 || y==158 || y==317). This is the 3x3 board-line pattern in visible coordinates, registered with the same 2-cycle latency as x/y.
- VGA_DECODER_GRID_EN undefined: on_grid is tied to 0 and no comparators are built.

## Structure
- Package vga_pkg holds:
  - the FSM state enum (SEARCH, MEASURE, VERIFY, LOCKED);
  - timing constants H_TOTAL=800, V_TOTAL=525, H_VIS=640, V_VIS=480;
  - grid constants GRID_X0=211, GRID_X1=423, GRID_Y0=158, GRID_Y1=317.
- One sub-module, vga_edge_det: a 1-bit registered edge detector producing rise/fall pulses. It is instantiated for hsync_n, vsync_n and blank.

## Test plan
- Standard 800x525 timing with 640x480 visible, rst_n released at frame mid-point: h_total=800 and v_total=525 after MEASURE; locked rises at the 4th frame event (LOCK_FRAMES=2).
- Locked stream: first visible pixel gives frame_start=1 and x=0/y=0 two cycles later; last visible pixel gives x=639, y=479.
- One line stretched to 801 clocks while locked: sync_err pulses once, locked falls 1 cycle after that line event, and lock is reacquired after the following frames.
- Frame with 524 lines while in VERIFY: sync_err pulses and the FSM returns to SEARCH; locked never asserts.
- rst_n asserted for 3 cycles mid-line while locked: all outputs return to reset values immediately and locked stays 0 until the relock sequence completes.
- VGA_DECODER_GRID_EN defined: on_grid=1 at (211,y), (423,y), (x,158) and (x,317), and 0 at (210,100). With the macro undefined, on_grid stays 0 throughout.
